// File: rtl/display_port_writer.sv
// display_port_writer: stages CPU port writes into {addr,att,chr} cells and drains them to display memory.
// Optional fill engine on port +5 is enabled by defining DISPLAY_PORT_WRITER_FILL_EN.
module display_port_writer #(
  parameter logic [7:0] PORT_BASE  = 8'h10,
  parameter int         ADDR_WIDTH = 12,
  parameter int         ADDR_LIMIT = 2400,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_write_strobe,
  input  logic [7:0]            cpu_port_id,
  input  logic [7:0]            cpu_write_data,
  output logic [7:0]            cpu_status,
  output logic                  mem_req,
  input  logic                  mem_grant,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_att_data,
  output logic [7:0]            mem_chr_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = ADDR_WIDTH + 16;
  function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
    return (p >= ADDR_WIDTH'(ADDR_LIMIT - 1)) ? '0 : p + ADDR_WIDTH'(1);
  endfunction
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  logic [7:0] attr, attr_n, chr, chr_n;
  logic ovf, ovf_n, push, pop, full, empty, busy, busy_n;
  logic [DW-1:0] push_cell;
  logic [DW-1:0] fifo [FIFO_DEPTH];
  logic [CW-1:0] wp, rp;
  logic sel_lo, sel_hi, sel_attr, sel_chr, sel_ctrl;
  assign sel_lo   = cpu_write_strobe && cpu_port_id == PORT_BASE;
  assign sel_hi   = cpu_write_strobe && cpu_port_id == PORT_BASE + 8'd1;
  assign sel_attr = cpu_write_strobe && cpu_port_id == PORT_BASE + 8'd2;
  assign sel_chr  = cpu_write_strobe && cpu_port_id == PORT_BASE + 8'd3;
  assign sel_ctrl = cpu_write_strobe && cpu_port_id == PORT_BASE + 8'd4;
  assign empty   = wp == rp;
  assign full    = (wp - rp) == CW'(FIFO_DEPTH);
  assign mem_req = !empty;
  assign mem_we  = mem_req & mem_grant;
  assign pop     = mem_we;
  assign {mem_addr, mem_att_data, mem_chr_data} = mem_req ? fifo[rp[AW-1:0]] : '0;
`ifdef DISPLAY_PORT_WRITER_FILL_EN
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [8:0] fcnt, fcnt_n;
  logic sel_fill;
  assign sel_fill = cpu_write_strobe && cpu_port_id == PORT_BASE + 8'd5;
  assign busy     = state == FILL;
  assign busy_n   = state_n == FILL;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
`else
  assign busy   = 1'b0;
  assign busy_n = 1'b0;
`endif
  always_comb begin
    ptr_n     = ptr;
    attr_n    = attr;
    chr_n     = chr;
    ovf_n     = ovf;
    push      = 1'b0;
    push_cell = {ptr, attr, chr};
    if (sel_ctrl && cpu_write_data[0]) ovf_n = 1'b0;
    if (!busy) begin
      if (sel_lo) ptr_n[7:0] = cpu_write_data;
      if (sel_hi) ptr_n[ADDR_WIDTH-1:8] = cpu_write_data[ADDR_WIDTH-9:0];
      if (sel_attr) attr_n = cpu_write_data;
      if (sel_chr) begin
        chr_n     = cpu_write_data;
        push_cell = {ptr, attr, cpu_write_data};
        ptr_n     = inc(ptr);
        push      = !full;
        if (full) ovf_n = 1'b1;
      end
    end else if (sel_chr) ovf_n = 1'b1;
`ifdef DISPLAY_PORT_WRITER_FILL_EN
    state_n = state;
    fcnt_n  = fcnt;
    if (state == IDLE && sel_fill) begin
      state_n = FILL;
      fcnt_n  = cpu_write_data == 8'd0 ? 9'd256 : {1'b0, cpu_write_data};
    end
    // Fill cells use the latched attr/char and stall whenever the FIFO is full.
    if (state == FILL && !full) begin
      push   = 1'b1;
      ptr_n  = inc(ptr);
      fcnt_n = fcnt - 9'd1;
      if (fcnt == 9'd1) state_n = IDLE;
    end
`endif
  end
  always_ff @(posedge clk)
    if (push) fifo[wp[AW-1:0]] <= push_cell;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ptr        <= '0;
      attr       <= 8'h07;
      chr        <= 8'h20;
      ovf        <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      cpu_status <= 8'h01;
    end else begin
      ptr        <= ptr_n;
      attr       <= attr_n;
      chr        <= chr_n;
      ovf        <= ovf_n;
      wp         <= wp + CW'(push);
      rp         <= rp + CW'(pop);
      cpu_status <= {5'b0, busy_n, ovf_n, (wp + CW'(push)) == (rp + CW'(pop))};
    end
endmodule

// File: tb/tb_display_port_writer.sv
// tb_display_port_writer: directed scoreboard bench for display_port_writer.
module tb_display_port_writer;
  logic clk = 1'b0, reset = 1'b0, cpu_write_strobe = 1'b0, mem_grant = 1'b0;
  logic [7:0] cpu_port_id = '0, cpu_write_data = '0, cpu_status, mem_att_data, mem_chr_data;
  logic mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [27:0] exp_q [$];
  int n_vec = 0, n_err = 0;

  display_port_writer dut (
    .clk(clk), .reset(reset), .cpu_write_strobe(cpu_write_strobe), .cpu_port_id(cpu_port_id),
    .cpu_write_data(cpu_write_data), .cpu_status(cpu_status), .mem_req(mem_req),
    .mem_grant(mem_grant), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_att_data(mem_att_data), .mem_chr_data(mem_chr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the oldest expected cell.
  always @(negedge clk)
    if (reset && mem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got %h%h%h expected none", mem_addr, mem_att_data, mem_chr_data);
      end else check("mem_write", {mem_addr, mem_att_data, mem_chr_data}, exp_q.pop_front());
    end

  task automatic wr(input logic [7:0] port, input logic [7:0] data);
    cpu_write_strobe = 1'b1;
    cpu_port_id = port;
    cpu_write_data = data;
    @(posedge clk);
    #1 cpu_write_strobe = 1'b0;
  endtask

  task automatic wr_chr(input logic [7:0] data, input logic [11:0] a, input logic [7:0] att, input bit acc);
    if (acc) exp_q.push_back({a, att, data});
    wr(8'h13, data);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(posedge clk);
      #1 k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_status", 28'(cpu_status), 28'h01);
    check("reset_mem_req", 28'(mem_req), 28'h0);
    // Basic cell write and auto-increment
    mem_grant = 1'b1;
    wr(8'h10, 8'h00);
    wr(8'h11, 8'h00);
    wr(8'h12, 8'h1E);
    wr_chr(8'h48, 12'h000, 8'h1E, 1);
    wr_chr(8'h49, 12'h001, 8'h1E, 1);
    drain(20);
    // Pointer wrap at last cell
    wr(8'h10, 8'h5F);
    wr(8'h11, 8'h09);
    wr_chr(8'h41, 12'h95F, 8'h1E, 1);
    wr_chr(8'h42, 12'h000, 8'h1E, 1);
    drain(20);
    // Overflow with grant withheld
    mem_grant = 1'b0;
    wr(8'h10, 8'h00);
    wr(8'h11, 8'h01);
    wr(8'h12, 8'h55);
    for (int i = 0; i < 5; i++) wr_chr(8'h61 + 8'(i), 12'h100 + 12'(i), 8'h55, i < 4);
    check("ovf_status", 28'(cpu_status), 28'h02);
    check("head_hold_addr", 28'(mem_addr), 28'h100);
    check("head_req", 28'(mem_req), 28'h1);
    repeat (3) @(posedge clk);
    #1 check("head_hold_chr", 28'(mem_chr_data), 28'h61);
    mem_grant = 1'b1;
    drain(20);
    check("ovf_sticky", 28'(cpu_status), 28'h03);
    wr(8'h14, 8'h01);
    check("ovf_clear", 28'(cpu_status), 28'h01);
    // Toggling grant with back-to-back writes; pointer continues at 0x105
    for (int i = 0; i < 6; i++) begin
      mem_grant = i[0];
      wr_chr(8'h70 + 8'(i), 12'h105 + 12'(i), 8'h55, 1);
    end
    mem_grant = 1'b1;
    drain(30);
    check("toggle_status", 28'(cpu_status), 28'h01);
`ifdef DISPLAY_PORT_WRITER_FILL_EN
    wr(8'h10, 8'h00);
    wr(8'h11, 8'h00);
    wr(8'h12, 8'h07);
    wr_chr(8'h20, 12'h000, 8'h07, 1);
    for (int i = 1; i <= 256; i++) exp_q.push_back({12'(i), 8'h07, 8'h20});
    wr(8'h15, 8'h00);
    repeat (5) @(posedge clk);
    #1 check("fill_busy", 28'(cpu_status[2]), 28'h1);
    repeat (100) @(posedge clk);
    #1 check("fill_busy_mid", 28'(cpu_status[2]), 28'h1);
    drain(400);
    check("fill_done_status", 28'(cpu_status), 28'h01);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
